// File: rtl/amm_ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// amm_ram_pkg : speed modes, LFSR step and wait-draw helpers for amm_ram_slave
// Rev 1.0
// ----------------------------------------------------------------------------
package amm_ram_pkg;

  typedef enum logic [1:0] {
    SPEED_SLOW   = 2'd0,
    SPEED_FAST   = 2'd1,
    SPEED_RANDOM = 2'd2
  } speed_mode_t;

  // Galois form of x^32 + x^22 + x^2 + x + 1, right-shifting
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic int unsigned ts_width(input int unsigned rd_wait_max);
    return $clog2(rd_wait_max) + 2;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Encoding 3 is not a named member and falls into the RANDOM branch.
  function automatic logic [31:0] draw_wait(input speed_mode_t mode,
                                            input logic [31:0] lfsr,
                                            input logic [31:0] wmin,
                                            input logic [31:0] wmax);
    logic [31:0] span;
    span = wmax - wmin + 32'd1;
    case (mode)
      SPEED_FAST: return wmin;
      SPEED_SLOW: return wmax;
      default:    return wmin + (lfsr % span);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/amm_ram_rsp_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// amm_ram_rsp_fifo : synchronous FIFO of {data, due} read responses
// Rev 1.0
// ----------------------------------------------------------------------------
module amm_ram_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle makes room for a push while full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/amm_ram_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// amm_ram_slave : Avalon-MM RAM slave with pipelined reads and drawn wait states
// Rev 1.0
// ----------------------------------------------------------------------------
module amm_ram_slave
  import amm_ram_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          ADDR_W      = 10,
  parameter int          MAX_PENDING = 4,
  parameter int          RD_WAIT_MIN = 1,
  parameter int          RD_WAIT_MAX = 64,
  parameter int          WR_WAIT_MIN = 1,
  parameter int          WR_WAIT_MAX = 1,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2025
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  input  logic [1:0]                         speed_mode_i,
  input  logic [ADDR_W-1:0]                  amm_address_i,
  input  logic                               amm_read_i,
  input  logic                               amm_write_i,
  input  logic [DATA_W-1:0]                  amm_writedata_i,
  input  logic [DATA_W/8-1:0]                amm_byteenable_i,
  output logic                               amm_waitrequest_o,
  output logic [DATA_W-1:0]                  amm_readdata_o,
  output logic                               amm_readdatavalid_o,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o,
  output logic                               proto_err_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int TS_W   = ts_width(RD_WAIT_MAX);
  localparam int WW     = $clog2(WR_WAIT_MAX + 1);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int ENT_W  = DATA_W + TS_W;

  typedef enum logic [0:0] {
    WR_IDLE  = 1'b0,
    WR_STALL = 1'b1
  } wr_state_t;

  wr_state_t         state_q, state_d;
  logic [WW-1:0]     wr_wait_q, wr_wait_d;
  logic [WW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [TS_W-1:0]   ts_q;
  logic              proto_err_q;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              wr_req, wr_acc, rd_acc;
  logic [31:0]       wr_draw_src;
  logic [WW-1:0]     wr_draw;
  logic [TS_W-1:0]   rd_lat;
  logic [ENT_W-1:0]  fifo_head, fifo_in;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [PEND_W-1:0] fifo_count;
  logic [DATA_W-1:0] head_data;
  logic [TS_W-1:0]   head_due, ts_diff;

  // The reset-time write draw comes straight from the seed.
  assign wr_draw_src = srst_i ? LFSR_SEED : lfsr_q;
  assign wr_draw = WW'(draw_wait(speed_mode_t'(speed_mode_i), wr_draw_src,
                                 32'(WR_WAIT_MIN), 32'(WR_WAIT_MAX)));
  assign rd_lat  = TS_W'(draw_wait(speed_mode_t'(speed_mode_i), lfsr_q,
                                   32'(RD_WAIT_MIN), 32'(RD_WAIT_MAX)));

  // A simultaneous read and write is serviced as a read only.
  assign wr_req = amm_write_i && !amm_read_i;

  assign head_data = fifo_head[ENT_W-1:TS_W];
  assign head_due  = fifo_head[TS_W-1:0];
  assign ts_diff   = ts_q - head_due;
  assign fifo_pop  = !fifo_empty && !ts_diff[TS_W-1];
  assign rd_acc    = amm_read_i && (!fifo_full || fifo_pop);
  assign fifo_in   = {mem_q[amm_address_i], ts_q + rd_lat};

  assign amm_waitrequest_o   = (amm_read_i && !rd_acc) || (wr_req && !wr_acc);
  assign amm_readdatavalid_o = fifo_pop;
  assign amm_readdata_o      = fifo_pop ? head_data : '0;
  assign pending_o           = fifo_count;
  assign proto_err_o         = proto_err_q;

  amm_ram_rsp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (MAX_PENDING),
    .CNT_W (PEND_W)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (rd_acc),
    .pop_i   (fifo_pop),
    .data_i  (fifo_in),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    wr_acc   = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (wr_req) begin
          if (wr_wait_q <= WW'(1)) begin
            wr_acc = 1'b1;
          end else begin
            state_d  = WR_STALL;
            wr_cnt_d = wr_wait_q - WW'(2);
          end
        end
      end
      WR_STALL: begin
        if (!wr_req) begin
          state_d = WR_IDLE;
        end else if (wr_cnt_q == '0) begin
          wr_acc  = 1'b1;
          state_d = WR_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q - WW'(1);
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  assign wr_wait_d = wr_acc ? wr_draw : wr_wait_q;
  assign lfsr_d    = (wr_acc || rd_acc) ? lfsr_step(lfsr_q) : lfsr_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= WR_IDLE;
      wr_cnt_q    <= '0;
      wr_wait_q   <= wr_draw;
      lfsr_q      <= LFSR_SEED;
      ts_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_wait_q   <= wr_wait_d;
      lfsr_q      <= lfsr_d;
      ts_q        <= ts_q + TS_W'(1);
      proto_err_q <= proto_err_q | (amm_read_i & amm_write_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc && !srst_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (amm_byteenable_i[b]) begin
          mem_q[amm_address_i][8*b +: 8] <= amm_writedata_i[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amm_ram_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_amm_ram_slave : scoreboard bench for amm_ram_slave
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_amm_ram_slave;

  localparam int DW   = 64;
  localparam int AW   = 10;
  localparam int MP   = 4;
  localparam int RMIN = 1;
  localparam int RMAX = 64;
  localparam int WMIN = 1;
  localparam int WMAX = 4;

  logic          clk, srst;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic          rd, wr;
  logic [DW-1:0] wdata;
  logic [7:0]    be;
  logic          waitreq;
  logic [DW-1:0] rdata;
  logic          rdv;
  logic [2:0]    pending;
  logic          perr;

  typedef struct {
    logic [DW-1:0] d;
    int            acc;
    int            lo;
    int            hi;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [2**AW];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            mpend    = 0;
  int            max_pend = 0;
  int            exp_w    = WMIN;
  int            last_lat = 0;
  logic [DW-1:0] last_rdata = '0;

  amm_ram_slave #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .MAX_PENDING (MP),
    .RD_WAIT_MIN (RMIN),
    .RD_WAIT_MAX (RMAX),
    .WR_WAIT_MIN (WMIN),
    .WR_WAIT_MAX (WMAX),
    .LFSR_SEED   (32'hACE1_2025)
  ) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .speed_mode_i        (mode),
    .amm_address_i       (addr),
    .amm_read_i          (rd),
    .amm_write_i         (wr),
    .amm_writedata_i     (wdata),
    .amm_byteenable_i    (be),
    .amm_waitrequest_o   (waitreq),
    .amm_readdata_o      (rdata),
    .amm_readdatavalid_o (rdv),
    .pending_o           (pending),
    .proto_err_o         (perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  // Monitor: compares responses against the scoreboard and keeps the memory model.
  initial begin
    forever begin
      @(negedge clk);
      if (srst) begin
        sb.delete();
        mpend = 0;
      end else begin
        check("pending", 64'(pending), 64'(mpend));
        if (int'(pending) > max_pend) max_pend = int'(pending);
        if (rd && waitreq)
          check("wait_only_full", 64'({pending == 3'(MP), rdv}), 64'd2);
        if (rdv) begin
          if (sb.size() == 0) begin
            check("spurious_rdv", 64'(rdv), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            last_rdata = rdata;
            last_lat   = cyc - e.acc;
            check("rdata", rdata, e.d);
            check("latency_in_range", 64'(last_lat >= e.lo && last_lat <= e.hi), 64'd1);
            mpend--;
          end
        end
        if (rd && !waitreq) begin
          exp_t n;
          n.d   = model[addr];
          n.acc = cyc;
          n.lo  = (mode == 2'd0) ? RMAX : RMIN;
          n.hi  = (mode == 2'd1) ? RMIN : RMAX;
          sb.push_back(n);
          mpend++;
        end
        if (wr && !rd && !waitreq) begin
          for (int b = 0; b < 8; b++)
            if (be[b]) model[addr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] e);
    int st;
    bit done;
    int exp_st;
    exp_st = exp_w - 1;
    st     = 0;
    done   = 1'b0;
    addr   = a;
    wdata  = d;
    be     = e;
    wr     = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!waitreq) done = 1'b1;
      else st++;
      @(posedge clk);
      #1;
    end
    wr = 1'b0;
    check("wr_accepted", 64'(done), 64'd1);
    check("wr_stall_cycles", 64'(st), 64'(exp_st));
    exp_w = (mode == 2'd0) ? WMAX : WMIN;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    addr = a;
    rd   = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!waitreq) done = 1'b1;
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
    check("rd_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    srst  = 1'b1;
    mode  = 2'd1;
    addr  = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    wdata = '0;
    be    = '0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;

    @(negedge clk);
    check("rst_waitreq", 64'(waitreq), 64'd0);
    check("rst_rdv", 64'(rdv), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_proto", 64'(perr), 64'd0);
    @(posedge clk);
    #1;

    // FAST write then read
    do_write(10'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    do_read(10'd5);
    wait_idle(10);
    check("fast_data", last_rdata, 64'hDEAD_BEEF_0123_4567);
    check("fast_latency", 64'(last_lat), 64'd1);

    // SLOW: first write redraws W=4, second write stalls three cycles
    mode = 2'd0;
    do_write(10'd8, 64'h1111_2222_3333_4444, 8'hFF);
    do_write(10'd7, 64'hCAFE_F00D_8BAD_F00D, 8'hFF);
    do_read(10'd7);
    wait_idle(100);
    check("slow_data", last_rdata, 64'hCAFE_F00D_8BAD_F00D);
    check("slow_latency", 64'(last_lat), 64'd64);

    // Byte-enable masking
    mode = 2'd1;
    do_write(10'd9, 64'd0, 8'hFF);
    do_write(10'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'b0000_0011);
    do_read(10'd9);
    wait_idle(10);
    check("be_data", last_rdata, 64'h0000_0000_0000_FFFF);

    for (int i = 16; i < 32; i++)
      do_write(AW'(i), {$urandom(), $urandom()}, 8'hFF);

    // RANDOM back-to-back reads
    mode = 2'd2;
    for (int i = 0; i < 1000; i++)
      do_read(AW'($urandom_range(16, 31)));
    wait_idle(300);
    check("max_pending", 64'(max_pend <= MP), 64'd1);

    // Read and write together
    mode = 2'd1;
    do_write(10'd3, 64'h0303_0303_0303_0303, 8'hFF);
    wr    = 1'b1;
    wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    be    = 8'hFF;
    do_read(10'd3);
    wr = 1'b0;
    wait_idle(10);
    check("rw_read_data", last_rdata, 64'h0303_0303_0303_0303);
    check("proto_set", 64'(perr), 64'd1);
    do_read(10'd3);
    wait_idle(10);
    check("rw_addr_unchanged", last_rdata, 64'h0303_0303_0303_0303);
    check("proto_sticky", 64'(perr), 64'd1);

    // Reset with three reads outstanding
    mode = 2'd0;
    do_read(10'd7);
    do_read(10'd7);
    do_read(10'd7);
    @(negedge clk);
    check("pending_three", 64'(pending), 64'd3);
    @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst  = 1'b0;
    exp_w = WMAX;
    @(negedge clk);
    check("post_rst_pending", 64'(pending), 64'd0);
    check("post_rst_proto", 64'(perr), 64'd0);
    check("post_rst_rdv", 64'(rdv), 64'd0);
    repeat (80) @(posedge clk);
    #1;
    mode = 2'd1;
    do_read(10'd7);
    wait_idle(10);
    check("post_rst_data", last_rdata, 64'hCAFE_F00D_8BAD_F00D);
    do_write(10'd11, 64'h0B0B_0B0B_0B0B_0B0B, 8'hFF);
    do_read(10'd11);
    wait_idle(10);
    check("post_rst_write", last_rdata, 64'h0B0B_0B0B_0B0B_0B0B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
